pdp_fetch_ctrl: RTL and testbench
=================================

PDP_FETCH_CTRL -- requirements
Module: pdp_fetch_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default `ADDR_WIDTH (12), address width; DATA_WIDTH, default `DATA_WIDTH (12), memory word width.
REQ-002 SHALL have ports (name, direction, width, meaning):
  - clk  in  1  sole clock, rising edge.
  - reset  in  1  synchronous reset, active-high.
  - stall  in  1  execution unit busy.
  - PC_value  in  ADDR_WIDTH  current PC from execution unit.
  - run  in  1  resume pulse after halt.
  - rd_req  out  1  single-cycle memory read request.
  - rd_addr  out  ADDR_WIDTH  read address, valid with rd_req.
  - rd_valid  in  1  read data valid pulse.
  - rd_data  in  DATA_WIDTH  read data.
  - base_addr  out  ADDR_WIDTH  address of the issued instruction.
  - pdp_mem_opcode  out  pdp_mem_opcode_s  {6-bit one-hot JMP..AND, 12-bit effective address}.
  - pdp_op7_opcode  out  pdp_op7_opcode_s  22-bit one-hot op7 decode.

Function
REQ-003 SHALL sequence states IDLE, FETCH, WAIT_INSTR, INDIR_REQ, INDIR_WAIT, ISSUE, WAIT_EXU, HALTED.
REQ-004 SHALL move IDLE->FETCH on the first cycle with stall==0.
REQ-005 SHALL, in FETCH, pulse rd_req for one cycle with rd_addr=PC_value, then enter WAIT_INSTR.
REQ-006 SHALL, in WAIT_INSTR, capture rd_data on rd_valid and decode bits[11:9]: 0 AND, 1 TAD, 2 ISZ, 3 DCA, 4 JMS, 5 JMP, 7 op7.
REQ-007 SHALL form the effective address as {PC_value[11:7], offset[6:0]} when bit7=1, and {5'b0, offset[6:0]} when bit7=0.
REQ-008 SHALL decode op7 words 7000 NOP, 7001 IAC, 7004 RAL, 7006 RTL, 7010 RAR, 7012 RTR, 7020 CML, 7040 CMA, 7041 CIA, 7100 CLL, 7200 CLA1, 7300 CLA_CLL, 7402 HLT, 7404 OSR, 7410 SKP, 7420 SNL, 7430 SZL, 7440 SZA, 7450 SNA, 7500 SMA, 7510 SPA and 7600 CLA2 (all octal) to the matching one-hot bit.
REQ-009 SHALL issue NOP for any other op7 word and for opcode 6 (IOT).
REQ-010 SHALL, in ISSUE, hold base_addr and exactly one one-hot opcode bit constant until a rising edge with stall==0 (acceptance), then enter WAIT_EXU.
REQ-011 SHALL hold both opcode outputs at zero in every state except ISSUE.
REQ-012 SHALL stay in WAIT_EXU for at least one cycle, then move to FETCH on the first cycle with stall==0, or to HALTED if the accepted instruction was HLT.
REQ-013 SHALL issue no rd_req in HALTED and SHALL move HALTED->FETCH on run==1.
REQ-014 SHALL ignore rd_valid outside WAIT_INSTR and INDIR_WAIT.
REQ-015 SHALL keep at most one read outstanding at any time.
REQ-016 SHALL allow an arbitrary rd_valid latency of one cycle or more.

Reset
REQ-017 SHALL, on reset, enter IDLE and drive rd_req=0, rd_addr=0, base_addr=0 and both opcodes=0 on the next edge.
REQ-018 SHALL apply reset mid-operation identically, discarding any outstanding read; a late rd_valid SHALL be ignored.

Configuration
REQ-019 SHALL, with PDP_INDIRECT_EN defined, treat bit8=1 on a memory-reference word as indirect: INDIR_REQ pulses rd_req at the effective address, and INDIR_WAIT uses the returned rd_data as the issued address.
REQ-020 SHALL, without PDP_INDIRECT_EN, ignore bit8, never enter INDIR_REQ/INDIR_WAIT, and go WAIT_INSTR->ISSUE directly.
REQ-021 SHALL perform no auto-index increment (addresses 0010-0017) in either configuration.

Structure
REQ-022 SHALL take pdp_mem_opcode_s, pdp_op7_opcode_s, the one-hot opcode constants and the state enum from the shared pdp package.
REQ-023 SHALL place the op7 decode table in a combinational sub-module pdp_op7_decode.

Verification
REQ-024 PC=0200, memory word 1205 -> ISSUE drives TAD with address 0205, base_addr=0200.
REQ-025 PDP_INDIRECT_EN defined, word 5410, mem[0010]=3000 -> second read at 0010, then JMP issued with address 3000.
REQ-026 Word 7041 -> CIA one-hot; word 7777 -> NOP.
REQ-027 Word 7402 -> HLT accepted, no rd_req for 20 cycles, run pulse -> rd_req at the new PC_value.
REQ-028 stall held high 5 cycles in ISSUE -> outputs constant, no rd_req; reset asserted in WAIT_INSTR with rd_valid one cycle later -> IDLE, all outputs 0, data ignored.

Source files
------------

// File: rtl/pdp_fetch_ctrl_pkg.sv
// Shared PDP-8 fetch types: FSM state enum, issued-opcode structs and one-hot constants.
package pdp_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_INSTR,
    S_INDIR_REQ,
    S_INDIR_WAIT,
    S_ISSUE,
    S_WAIT_EXU,
    S_HALTED
  } pdp_state_e;

  // op: one-hot {JMP, JMS, DCA, ISZ, TAD, AND}, addr: effective address
  typedef struct packed {
    logic [5:0]  op;
    logic [11:0] addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic [21:0] op;
  } pdp_op7_opcode_s;

  localparam logic [5:0] MEM_AND = 6'b000001;
  localparam logic [5:0] MEM_TAD = 6'b000010;
  localparam logic [5:0] MEM_ISZ = 6'b000100;
  localparam logic [5:0] MEM_DCA = 6'b001000;
  localparam logic [5:0] MEM_JMS = 6'b010000;
  localparam logic [5:0] MEM_JMP = 6'b100000;

  localparam logic [21:0] OP7_NOP     = 22'b1 << 0;
  localparam logic [21:0] OP7_IAC     = 22'b1 << 1;
  localparam logic [21:0] OP7_RAL     = 22'b1 << 2;
  localparam logic [21:0] OP7_RTL     = 22'b1 << 3;
  localparam logic [21:0] OP7_RAR     = 22'b1 << 4;
  localparam logic [21:0] OP7_RTR     = 22'b1 << 5;
  localparam logic [21:0] OP7_CML     = 22'b1 << 6;
  localparam logic [21:0] OP7_CMA     = 22'b1 << 7;
  localparam logic [21:0] OP7_CIA     = 22'b1 << 8;
  localparam logic [21:0] OP7_CLL     = 22'b1 << 9;
  localparam logic [21:0] OP7_CLA1    = 22'b1 << 10;
  localparam logic [21:0] OP7_CLA_CLL = 22'b1 << 11;
  localparam logic [21:0] OP7_HLT     = 22'b1 << 12;
  localparam logic [21:0] OP7_OSR     = 22'b1 << 13;
  localparam logic [21:0] OP7_SKP     = 22'b1 << 14;
  localparam logic [21:0] OP7_SNL     = 22'b1 << 15;
  localparam logic [21:0] OP7_SZL     = 22'b1 << 16;
  localparam logic [21:0] OP7_SZA     = 22'b1 << 17;
  localparam logic [21:0] OP7_SNA     = 22'b1 << 18;
  localparam logic [21:0] OP7_SMA     = 22'b1 << 19;
  localparam logic [21:0] OP7_SPA     = 22'b1 << 20;
  localparam logic [21:0] OP7_CLA2    = 22'b1 << 21;

  function automatic logic [5:0] mem_onehot(input logic [2:0] opc);
    logic [5:0] oh;
    oh = '0;
    case (opc)
      3'd0:    oh = MEM_AND;
      3'd1:    oh = MEM_TAD;
      3'd2:    oh = MEM_ISZ;
      3'd3:    oh = MEM_DCA;
      3'd4:    oh = MEM_JMS;
      3'd5:    oh = MEM_JMP;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/pdp_fetch_ctrl_if.sv
// Memory read port of the PDP fetch controller: one request at a time, data returned on rd_valid.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

interface pdp_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_valid, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_valid, output rd_data);
endinterface

// File: rtl/pdp_op7_decode.sv
// Combinational decode of group-7 operate words to the one-hot op7 opcode; unknown words become NOP.
module pdp_op7_decode
  import pdp_fetch_ctrl_pkg::*;
(
  input  logic [11:0]     word,
  output pdp_op7_opcode_s op7
);

  always_comb begin
    op7.op = OP7_NOP;
    case (word)
      12'o7001: op7.op = OP7_IAC;
      12'o7004: op7.op = OP7_RAL;
      12'o7006: op7.op = OP7_RTL;
      12'o7010: op7.op = OP7_RAR;
      12'o7012: op7.op = OP7_RTR;
      12'o7020: op7.op = OP7_CML;
      12'o7040: op7.op = OP7_CMA;
      12'o7041: op7.op = OP7_CIA;
      12'o7100: op7.op = OP7_CLL;
      12'o7200: op7.op = OP7_CLA1;
      12'o7300: op7.op = OP7_CLA_CLL;
      12'o7402: op7.op = OP7_HLT;
      12'o7404: op7.op = OP7_OSR;
      12'o7410: op7.op = OP7_SKP;
      12'o7420: op7.op = OP7_SNL;
      12'o7430: op7.op = OP7_SZL;
      12'o7440: op7.op = OP7_SZA;
      12'o7450: op7.op = OP7_SNA;
      12'o7500: op7.op = OP7_SMA;
      12'o7510: op7.op = OP7_SPA;
      12'o7600: op7.op = OP7_CLA2;
      default:  op7.op = OP7_NOP;
    endcase
  end

endmodule

// File: rtl/pdp_fetch_ctrl.sv
// PDP-8 instruction fetch/decode sequencer. Define PDP_INDIRECT_EN to enable indirect (bit8) addressing.
//   state        | meaning
//   S_IDLE       | after reset, wait for stall low
//   S_FETCH      | one-cycle read of the word at PC_value
//   S_WAIT_INSTR | wait for the instruction word, decode it
//   S_INDIR_REQ  | one-cycle read of the indirect pointer
//   S_INDIR_WAIT | wait for the pointer, it becomes the issued address
//   S_ISSUE      | present opcode until accepted (stall low)
//   S_WAIT_EXU   | execution running, wait for stall low
//   S_HALTED     | HLT accepted, wait for run
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp_fetch_ctrl
  import pdp_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [ADDR_WIDTH-1:0]   PC_value,
  input  logic                    run,
  pdp_fetch_ctrl_if.master        mem_bus,
  output logic [ADDR_WIDTH-1:0]   base_addr,
  output pdp_mem_opcode_s         pdp_mem_opcode,
  output pdp_op7_opcode_s         pdp_op7_opcode
);

  pdp_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  pdp_mem_opcode_s       mem_q, mem_d;
  pdp_op7_opcode_s       op7_q, op7_d;

  logic [DATA_WIDTH-1:0] word;
  logic [11:0]           ea;
  logic                  is_mem;
  logic                  indirect;
  pdp_op7_opcode_s       op7_dec;

  assign word   = mem_bus.rd_data;
  assign is_mem = (word[11:9] <= 3'd5);
  assign ea     = word[7] ? {PC_value[11:7], word[6:0]} : {5'b0, word[6:0]};

`ifdef PDP_INDIRECT_EN
  assign indirect = is_mem & word[8];
`else
  assign indirect = 1'b0;
`endif

  // IOT (opcode 6) words never match the table, so they decode to NOP as well
  pdp_op7_decode u_op7_decode (
    .word (word[11:0]),
    .op7  (op7_dec)
  );

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    mem_d            = mem_q;
    op7_d            = op7_q;
    mem_bus.rd_req   = 1'b0;
    mem_bus.rd_addr  = '0;
    base_addr        = base_q;
    pdp_mem_opcode   = '0;
    pdp_op7_opcode   = '0;
    case (state_q)
      S_IDLE: if (!stall) state_d = S_FETCH;
      S_FETCH: begin
        mem_bus.rd_req  = 1'b1;
        mem_bus.rd_addr = PC_value;
        base_d          = PC_value;
        state_d         = S_WAIT_INSTR;
      end
      S_WAIT_INSTR: if (mem_bus.rd_valid) begin
        if (is_mem) begin
          mem_d.op   = mem_onehot(word[11:9]);
          mem_d.addr = ea;
          op7_d      = '0;
        end else begin
          mem_d = '0;
          op7_d = op7_dec;
        end
        state_d = indirect ? S_INDIR_REQ : S_ISSUE;
      end
      S_INDIR_REQ: begin
        mem_bus.rd_req  = 1'b1;
        mem_bus.rd_addr = ADDR_WIDTH'(mem_q.addr);
        state_d         = S_INDIR_WAIT;
      end
      S_INDIR_WAIT: if (mem_bus.rd_valid) begin
        mem_d.addr = word[11:0];
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        pdp_mem_opcode = mem_q;
        pdp_op7_opcode = op7_q;
        if (!stall) state_d = S_WAIT_EXU;
      end
      S_WAIT_EXU: if (!stall) state_d = (op7_q.op == OP7_HLT) ? S_HALTED : S_FETCH;
      S_HALTED:   if (run) state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      mem_q   <= '0;
      op7_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mem_q   <= mem_d;
      op7_q   <= op7_d;
    end
  end

endmodule

// File: tb/tb_pdp_fetch_ctrl.sv
// Self-checking bench for pdp_fetch_ctrl: directed steps plus randomized words against a word-level model.
module tb_pdp_fetch_ctrl;
  import pdp_fetch_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            run;
  logic [11:0]     PC_value;
  logic [11:0]     base_addr;
  pdp_mem_opcode_s pdp_mem_opcode;
  pdp_op7_opcode_s pdp_op7_opcode;

  pdp_fetch_ctrl_if bus ();

  pdp_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .PC_value       (PC_value),
    .run            (run),
    .mem_bus        (bus),
    .base_addr      (base_addr),
    .pdp_mem_opcode (pdp_mem_opcode),
    .pdp_op7_opcode (pdp_op7_opcode)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [11:0] mem [0:4095];
  // op7 words in one-hot bit order
  logic [11:0] op7_codes [22] = '{12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012,
                                  12'o7020, 12'o7040, 12'o7041, 12'o7100, 12'o7200, 12'o7300,
                                  12'o7402, 12'o7404, 12'o7410, 12'o7420, 12'o7430, 12'o7440,
                                  12'o7450, 12'o7500, 12'o7510, 12'o7600};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait lat cycles after a request, counting any further requests, then return data once.
  task automatic serve(input int lat, input logic [11:0] data);
    int extra;
    extra = 0;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (bus.rd_req === 1'b1) extra++;
    end
    bus.rd_valid = 1'b1;
    bus.rd_data  = data;
    tick();
    bus.rd_valid = 1'b0;
    bus.rd_data  = 12'($urandom);
    chk("single_outstanding", 64'(extra), 64'd0);
  endtask

  task automatic run_instr(input logic [11:0] pc, input logic [11:0] word,
                           input int lat, input int stall_n);
    logic [5:0]  e_op;
    logic [11:0] e_addr;
    logic [21:0] e_op7;
    logic        ind;
    int unsigned opc;
    int          waited;
    int          bad;

    mem[pc]  = word;
    PC_value = pc;
    stall    = 1'b0;

    opc   = 32'(word) / 512;
    e_op  = '0;
    e_op7 = '0;
    ind   = 1'b0;
    if (opc <= 5) begin
      e_op   = 6'(1 << opc);
      e_addr = word[7] ? ((pc & 12'o7600) | (word & 12'o177)) : (word & 12'o177);
`ifdef PDP_INDIRECT_EN
      ind = word[8];
`endif
    end else begin
      e_addr = '0;
      e_op7  = 22'd1;
      if (opc == 7)
        for (int i = 0; i < 22; i++) if (op7_codes[i] == word) e_op7 = 22'(1) << i;
    end

    waited = 0;
    while (bus.rd_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("fetch_req", 64'(bus.rd_req), 64'd1);
    chk("fetch_addr", 64'(bus.rd_addr), 64'(pc));
    stall = (stall_n > 0);
    serve(lat, word);

    if (ind) begin
      chk("indir_req", 64'(bus.rd_req), 64'd1);
      chk("indir_addr", 64'(bus.rd_addr), 64'(e_addr));
      e_addr = mem[e_addr];
      serve(lat, e_addr);
    end

    chk("issue_mem", 64'(pdp_mem_opcode), 64'({e_op, e_addr}));
    chk("issue_op7", 64'(pdp_op7_opcode), 64'(e_op7));
    chk("issue_base", 64'(base_addr), 64'(pc));

    bad = 0;
    for (int i = 0; i < stall_n; i++) begin
      bus.rd_valid = 1'($urandom);
      bus.rd_data  = 12'($urandom);
      tick();
      if (pdp_mem_opcode !== {e_op, e_addr} || pdp_op7_opcode !== e_op7 ||
          base_addr !== pc || bus.rd_req !== 1'b0) bad++;
    end
    bus.rd_valid = 1'b0;
    if (stall_n > 0) chk("stall_hold", 64'(bad), 64'd0);

    stall = 1'b0;
    tick();
    chk("exu_quiet", 64'({pdp_mem_opcode, pdp_op7_opcode, bus.rd_req}), 64'd0);
  endtask

  task automatic reset_zero(input string tag);
    chk({tag, "_rd_req"}, 64'(bus.rd_req), 64'd0);
    chk({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
    chk({tag, "_base"}, 64'(base_addr), 64'd0);
    chk({tag, "_opcodes"}, 64'({pdp_mem_opcode, pdp_op7_opcode}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    logic [11:0] w;

    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    reset        = 1'b1;
    stall        = 1'b1;
    run          = 1'b0;
    PC_value     = '0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    repeat (3) tick();
    reset_zero("reset");

    // IDLE must wait for stall low
    reset = 1'b0;
    cnt = 0;
    repeat (4) begin
      tick();
      if (bus.rd_req === 1'b1) cnt++;
    end
    chk("idle_stalled", 64'(cnt), 64'd0);

    run_instr(12'o0200, 12'o1205, 1, 0);
    run_instr(12'o0400, 12'o7041, 2, 0);
    run_instr(12'o0401, 12'o7777, 3, 1);
    run_instr(12'o0402, 12'o6123, 1, 0);
    run_instr(12'o1234, 12'o3377, 2, 5);
    run_instr(12'o2345, 12'o0077, 4, 0);

    mem[12'o0010] = 12'o3000;
    run_instr(12'o0500, 12'o5410, 2, 0);

    run_instr(12'o0600, 12'o7402, 1, 0);
    cnt = 0;
    repeat (20) begin
      tick();
      if (bus.rd_req === 1'b1) cnt++;
    end
    chk("halt_no_req", 64'(cnt), 64'd0);
    PC_value = 12'o0777;
    run      = 1'b1;
    tick();
    run = 1'b0;
    chk("run_req", 64'(bus.rd_req), 64'd1);
    run_instr(12'o0777, 12'o7200, 1, 2);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) w = op7_codes[$urandom_range(0, 21)];
      else w = 12'($urandom);
      if (w == 12'o7402) w = 12'o7404;
      run_instr(12'($urandom), w, $urandom_range(1, 4), $urandom_range(0, 3));
    end

    // reset while a read is outstanding; the late data must not be used
    PC_value = 12'o0300;
    cnt = 0;
    while (bus.rd_req !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("pre_reset_req", 64'(bus.rd_req), 64'd1);
    tick();
    stall = 1'b1;
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.rd_valid = 1'b1;
    bus.rd_data  = 12'o7402;
    reset_zero("midreset");
    tick();
    bus.rd_valid = 1'b0;
    cnt = 0;
    repeat (4) begin
      if (bus.rd_req === 1'b1 || pdp_op7_opcode !== '0 || pdp_mem_opcode !== '0) cnt++;
      tick();
    end
    chk("late_valid_ignored", 64'(cnt), 64'd0);
    run_instr(12'o0310, 12'o4321, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
